// File: rtl/rst_seq_pkg.sv
// Shared SoC reset-sequencer definitions: the state encoding and the default timing constants.
package rst_seq_pkg;

    typedef enum logic [2:0] {
        HOLD      = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        SYS_UP    = 3'd3,
        RUN       = 3'd4
    } state_e;

    localparam int unsigned DEF_LOCK_CYCLES = 1024;
    localparam int unsigned DEF_CPU_DELAY   = 64;
    localparam int unsigned DEF_HOLD_CYCLES = 16;
    localparam int unsigned LLC_W           = 8;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/rst_seq_sync2.sv
// Generic two-flop synchronizer with asynchronous active-low clear; output is the second flop.
module sync2 (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/rst_seq.sv
// Power-up / PLL-lock reset sequencer: holds, waits for stable lock, releases sys_rst, then the CPU.
module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int unsigned LOCK_CYCLES = DEF_LOCK_CYCLES,
    parameter int unsigned CPU_DELAY   = DEF_CPU_DELAY,
    parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic             pll_locked,
    input  logic             sw_rst,
    output logic             sys_rst,
    output logic             cpu_rst_n,
    output logic             ready,
    output logic [LLC_W-1:0] lock_loss_cnt,
    output state_e           dbg_state_o
);

    localparam int unsigned MAX_P = max3(LOCK_CYCLES, CPU_DELAY, HOLD_CYCLES);
    localparam int unsigned CW    = (MAX_P > 1) ? $clog2(MAX_P) : 1;

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_CYCLES - 1);
    localparam logic [CW-1:0] CPU_LAST  = CW'(CPU_DELAY - 1);

    logic             locked_s;
    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [LLC_W-1:0] llc_q, llc_d;
    logic             sys_rst_q, cpu_rst_n_q, ready_q;
    logic             cnt_inc, cnt_clr, loss;

    sync2 u_sync (
        .clk_i   (sys_clk),
        .rst_n_i (rst_n),
        .d_i     (pll_locked),
        .q_o     (locked_s)
    );

    always_comb begin
        state_d = state_q;
        cnt_inc = 1'b0;
        cnt_clr = 1'b0;
        loss    = 1'b0;
        case (state_q)
            HOLD: begin
                if (sw_rst)                  cnt_clr = 1'b1;
                else if (cnt_q == HOLD_LAST) state_d = WAIT_LOCK;
                else                         cnt_inc = 1'b1;
            end
            WAIT_LOCK: begin
                if (locked_s) state_d = STABLE;
            end
            STABLE: begin
                if (!locked_s)               state_d = WAIT_LOCK;
                else if (cnt_q == LOCK_LAST) state_d = SYS_UP;
                else                         cnt_inc = 1'b1;
            end
            SYS_UP, RUN: begin
                // Lock loss takes priority over a coincident soft reset.
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    loss    = 1'b1;
                end else if (sw_rst) begin
                    state_d = HOLD;
                end else if (state_q == SYS_UP) begin
                    if (cnt_q == CPU_LAST) state_d = RUN;
                    else                   cnt_inc = 1'b1;
                end
            end
            default: state_d = HOLD;
        endcase

        if ((state_d != state_q) || cnt_clr) cnt_d = '0;
        else if (cnt_inc)                    cnt_d = cnt_q + 1'b1;
        else                                 cnt_d = cnt_q;

        llc_d = (loss && (llc_q != {LLC_W{1'b1}})) ? llc_q + 1'b1 : llc_q;
    end

    // Outputs decode the next state so they switch on the same edge as the state register.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HOLD;
            cnt_q       <= '0;
            llc_q       <= '0;
            sys_rst_q   <= 1'b1;
            cpu_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            llc_q       <= llc_d;
            sys_rst_q   <= !((state_d == SYS_UP) || (state_d == RUN));
            cpu_rst_n_q <= (state_d == RUN);
            ready_q     <= (state_d == RUN);
        end
    end

    assign sys_rst       = sys_rst_q;
    assign cpu_rst_n     = cpu_rst_n_q;
    assign ready         = ready_q;
    assign lock_loss_cnt = llc_q;
    assign dbg_state_o   = state_q;

endmodule
